// File: rtl/wm_dma_pkg.sv
// Shared types and constants for the WM-to-DM copy engine.
//   state_t        : FSM state encoding (IDLE, RD, CAP, WR)
//   REG_*          : config-port register offsets
//   CTRL_*/STAT_*  : bit positions in the CTRL (write) / STATUS (read) register
package wm_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    WR   = 2'd3
  } state_t;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_CLR_DONE = 1;
  localparam int unsigned STAT_BUSY     = 0;
  localparam int unsigned STAT_DONE     = 1;

endpackage

// File: rtl/wm_dma.sv
// Block copy engine: reads LEN words from WM starting at SRC and writes them
// to DM starting at DST, one word per RD/CAP/WR pass.
// Ports:
//   clk, rst                    : clock, async active-high reset
//   cfg_we/addr/wdata/rdata     : four-register config port (rdata is combinational)
//   wm_cs, wm_oe, wm_a, wm_do   : WM read port (1-cycle read latency)
//   dm_req, dm_gnt, dm_a,
//   dm_web, dm_di               : DM write request toward the arbiter
//   irq                         : level copy of the done flag
module wm_dma
  import wm_dma_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  output logic              wm_cs,
  output logic              wm_oe,
  output logic [ADDR_W-1:0] wm_a,
  input  logic [DATA_W-1:0] wm_do,
  output logic              dm_req,
  input  logic              dm_gnt,
  output logic [ADDR_W-1:0] dm_a,
  output logic [3:0]        dm_web,
  output logic [DATA_W-1:0] dm_di,
  output logic              irq
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] src_q, dst_q, len_q;
  logic [ADDR_W-1:0] src_cnt, dst_cnt, rem;
  logic [DATA_W-1:0] data_q;
  logic              done_q;

  logic ctrl_wr_c, start_c, clr_c, grant_c, last_c, len_zero_c;

  // Only the address-sized low bits of SRC/DST/LEN writes are stored.
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata[31:ADDR_W];

  assign ctrl_wr_c  = cfg_we && (cfg_addr == REG_CTRL);
  assign start_c    = ctrl_wr_c && cfg_wdata[CTRL_START] && (state_q == IDLE);
  assign clr_c      = ctrl_wr_c && cfg_wdata[CTRL_CLR_DONE];
  assign len_zero_c = (len_q == '0);
  assign grant_c    = (state_q == WR) && dm_gnt;
  assign last_c     = grant_c && (rem == ADDR_W'(1));

  // Programmed registers; frozen while a transfer is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
    end else if (cfg_we && (state_q == IDLE)) begin
      case (cfg_addr)
        REG_SRC: src_q <= cfg_wdata[ADDR_W-1:0];
        REG_DST: dst_q <= cfg_wdata[ADDR_W-1:0];
        REG_LEN: len_q <= cfg_wdata[ADDR_W-1:0];
        default: ;
      endcase
    end
  end

  // Done flag: completion wins over a same-cycle clear; start overrides clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else if (last_c) begin
      done_q <= 1'b1;
    end else if (start_c) begin
      done_q <= len_zero_c;
    end else if (clr_c) begin
      done_q <= 1'b0;
    end
  end

  // Running counters and the captured read word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_cnt <= '0;
      dst_cnt <= '0;
      rem     <= '0;
      data_q  <= '0;
    end else begin
      if (start_c && !len_zero_c) begin
        src_cnt <= src_q;
        dst_cnt <= dst_q;
        rem     <= len_q;
      end else if (grant_c) begin
        src_cnt <= src_cnt + ADDR_W'(1);
        dst_cnt <= dst_cnt + ADDR_W'(1);
        rem     <= rem - ADDR_W'(1);
      end
      if (state_q == CAP) begin
        data_q <= wm_do;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and SRAM-side outputs, decoded from the registered state.
  always_comb begin
    state_d = state_q;
    wm_cs   = 1'b0;
    wm_oe   = 1'b0;
    wm_a    = '0;
    dm_req  = 1'b0;
    dm_a    = '0;
    dm_web  = 4'hF;
    dm_di   = '0;
    case (state_q)
      IDLE: begin
        if (start_c && !len_zero_c) state_d = RD;
      end
      RD: begin
        wm_cs   = 1'b1;
        wm_oe   = 1'b1;
        wm_a    = src_cnt;
        state_d = CAP;
      end
      CAP: begin
        state_d = WR;
      end
      WR: begin
        dm_req = 1'b1;
        dm_a   = dst_cnt;
        dm_web = 4'h0;
        dm_di  = data_q;
        if (dm_gnt) state_d = (rem == ADDR_W'(1)) ? IDLE : RD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Readback shows programmed values, not the running counters.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      REG_SRC: cfg_rdata = 32'(src_q);
      REG_DST: cfg_rdata = 32'(dst_q);
      REG_LEN: cfg_rdata = 32'(len_q);
      default: begin
        cfg_rdata[STAT_BUSY] = (state_q != IDLE);
        cfg_rdata[STAT_DONE] = done_q;
      end
    endcase
  end

  assign irq = done_q;

endmodule

// File: tb/tb_wm_dma.sv
// Directed bench for wm_dma with a transaction-level reference model.
module tb_wm_dma;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_addr = 2'd3;
  logic [31:0]       cfg_wdata = '0;
  logic [31:0]       cfg_rdata;
  logic              wm_cs, wm_oe;
  logic [ADDR_W-1:0] wm_a;
  logic [DATA_W-1:0] wm_do = '0;
  logic              dm_req;
  logic              dm_gnt = 1'b1;
  logic [ADDR_W-1:0] dm_a;
  logic [3:0]        dm_web;
  logic [DATA_W-1:0] dm_di;
  logic              irq;

  wm_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .wm_cs(wm_cs), .wm_oe(wm_oe), .wm_a(wm_a), .wm_do(wm_do),
    .dm_req(dm_req), .dm_gnt(dm_gnt), .dm_a(dm_a), .dm_web(dm_web), .dm_di(dm_di),
    .irq(irq)
  );

  always #5 clk = ~clk;

  bit [31:0] wm_mem [DEPTH];
  bit [31:0] dm_mem [DEPTH];

  // WM SRAM: data appears one cycle after the address.
  always @(posedge clk) if (wm_cs && wm_oe) wm_do <= wm_mem[wm_a];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  logic [ADDR_W-1:0] m_src = '0, m_dst = '0, m_len = '0;
  bit                m_busy = 1'b0, m_done = 1'b0;
  logic [ADDR_W-1:0] exp_rd [$];
  wr_t               exp_wr [$];
  logic [ADDR_W-1:0] rd_log [$];
  int                wr_count = 0;
  bit                stall_prev = 1'b0;
  logic [ADDR_W-1:0] stall_a, ra, wa;
  logic [31:0]       stall_d;
  wr_t               w;

  function automatic logic [31:0] model_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_src);
      2'd1:    return 32'(m_dst);
      2'd2:    return 32'(m_len);
      default: return {30'd0, m_done, m_busy};
    endcase
  endfunction

  // Compare process: every negedge, check outputs then advance the model
  // by what the upcoming posedge will do.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_outputs", {wm_cs, wm_oe, dm_req, dm_web, irq}, {1'b0, 1'b0, 1'b0, 4'hF, 1'b0});
      m_src = '0; m_dst = '0; m_len = '0; m_busy = 0; m_done = 0;
      exp_rd.delete(); exp_wr.delete(); stall_prev = 0;
    end else begin
      chk("cfg_rdata", cfg_rdata, model_rdata(cfg_addr));
      chk("irq", irq, m_done);
      chk("dm_web", dm_web, dm_req ? 4'h0 : 4'hF);
      if (stall_prev) begin
        chk("stall_req", dm_req, 1'b1);
        chk("stall_a", dm_a, stall_a);
        chk("stall_di", dm_di, stall_d);
      end
      if (wm_cs) begin
        rd_log.push_back(wm_a);
        chk("wm_oe", wm_oe, 1'b1);
        if (exp_rd.size() == 0) chk("wm_spurious_read", 1'b1, 1'b0);
        else chk("wm_a", wm_a, exp_rd.pop_front());
      end
      if (cfg_we) begin
        if (cfg_addr == 2'd3) begin
          if (cfg_wdata[1]) m_done = 0;
          if (cfg_wdata[0] && !m_busy) begin
            if (m_len == 0) m_done = 1;
            else begin
              m_busy = 1; m_done = 0;
              for (int i = 0; i < int'(m_len); i++) begin
                ra = m_src + ADDR_W'(i);
                wa = m_dst + ADDR_W'(i);
                exp_rd.push_back(ra);
                exp_wr.push_back('{a: wa, d: wm_mem[ra]});
              end
            end
          end
        end else if (!m_busy) begin
          case (cfg_addr)
            2'd0: m_src = cfg_wdata[ADDR_W-1:0];
            2'd1: m_dst = cfg_wdata[ADDR_W-1:0];
            default: m_len = cfg_wdata[ADDR_W-1:0];
          endcase
        end
      end
      if (dm_req && dm_gnt) begin
        wr_count++;
        dm_mem[dm_a] = dm_di;
        if (exp_wr.size() == 0) chk("dm_spurious_write", 1'b1, 1'b0);
        else begin
          w = exp_wr.pop_front();
          chk("dm_a", dm_a, w.a);
          chk("dm_di", dm_di, w.d);
          if (exp_wr.size() == 0) begin
            m_busy = 0; m_done = 1;
          end
        end
      end
      stall_prev = dm_req && !dm_gnt;
      stall_a = dm_a;
      stall_d = dm_di;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0; cfg_addr = 2'd3; cfg_wdata = '0;
  endtask

  task automatic start_xfer(input int src, input int dst, input int len);
    cfg_write(2'd0, 32'(src));
    cfg_write(2'd1, 32'(dst));
    cfg_write(2'd2, 32'(len));
    cfg_write(2'd3, 32'h1);
  endtask

  // Counts edges after the start edge until irq; grant held low before edge gnt_from.
  task automatic run_until_irq(input int gnt_from, output int cyc);
    cyc = 0;
    dm_gnt = (gnt_from <= 0);
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      if (irq) break;
      dm_gnt = (cyc >= gnt_from);
      if (cyc > 300) begin
        checks++; failures++;
        $display("FAIL irq_timeout actual=%0d cycles required=irq", cyc);
        break;
      end
    end
    dm_gnt = 1'b1;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
    cfg_addr = a; #1;
    v = cfg_rdata;
    cfg_addr = 2'd3;
  endtask

  int          cyc, wc, base;
  logic [31:0] v;

  initial begin
    for (int i = 0; i < 4; i++) begin
      wm_mem[16'h10 + i] = 32'hA0 + 32'(i);
      wm_mem[16'h20 + i] = 32'hD0 + 32'(i);
      wm_mem[16'h40 + i] = 32'hC0 + 32'(i);
    end
    wm_mem[16'h30] = 32'hE0; wm_mem[16'h31] = 32'hE1;
    wm_mem[16'h3FFE] = 32'hB0; wm_mem[16'h3FFF] = 32'hB1; wm_mem[0] = 32'hB2;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dm_web", dm_web, 4'hF);
    chk("reset_ports", {wm_cs, wm_oe, wm_a, dm_req, dm_a, dm_di, irq}, '0);
    for (int a = 0; a < 4; a++) begin
      read_reg(2'(a), v);
      chk("reset_reg", v, 32'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic copy
    start_xfer(32'h10, 32'h2000, 4);
    run_until_irq(0, cyc);
    chk("t1_irq_cycles", cyc, 12);
    for (int i = 0; i < 4; i++) chk("t1_dm_word", dm_mem[16'h2000 + i], 32'hA0 + 32'(i));
    read_reg(2'd3, v);
    chk("t1_status", v, 32'h2);

    // Zero length
    cfg_write(2'd3, 32'h2);
    chk("t2_clear", irq, 1'b0);
    base = rd_log.size(); wc = wr_count;
    cfg_write(2'd2, 32'h0);
    cfg_write(2'd3, 32'h1);
    chk("t2_irq_at_start", irq, 1'b1);
    read_reg(2'd3, v);
    chk("t2_status", v, 32'h2);
    repeat (4) @(posedge clk);
    #1;
    chk("t2_no_reads", rd_log.size() - base, 0);
    chk("t2_no_writes", wr_count - wc, 0);

    // Stalled grant on word 0
    wc = wr_count;
    start_xfer(32'h30, 32'h700, 2);
    run_until_irq(7, cyc);
    chk("t3_irq_cycles", cyc, 11);
    chk("t3_writes", wr_count - wc, 2);
    chk("t3_dm0", dm_mem[16'h700], 32'hE0);
    chk("t3_dm1", dm_mem[16'h701], 32'hE1);

    // Address wrap
    base = rd_log.size();
    start_xfer(32'h3FFE, 32'h3FFF, 3);
    run_until_irq(0, cyc);
    chk("t4_irq_cycles", cyc, 9);
    chk("t4_reads", rd_log.size() - base, 3);
    chk("t4_rd0", rd_log[base],     14'h3FFE);
    chk("t4_rd1", rd_log[base + 1], 14'h3FFF);
    chk("t4_rd2", rd_log[base + 2], 14'h0000);
    chk("t4_dm3fff", dm_mem[16'h3FFF], 32'hB0);
    chk("t4_dm0000", dm_mem[0], 32'hB1);
    chk("t4_dm0001", dm_mem[1], 32'hB2);

    // Writes while busy are ignored
    wc = wr_count;
    start_xfer(32'h20, 32'h600, 4);
    cfg_write(2'd0, 32'h100);
    cfg_write(2'd3, 32'h1);
    run_until_irq(0, cyc);
    chk("t5_writes", wr_count - wc, 4);
    read_reg(2'd0, v);
    chk("t5_src_kept", v, 32'h20);
    chk("t5_dm_last", dm_mem[16'h603], 32'hD3);
    cfg_write(2'd3, 32'h2);
    chk("t5_irq_cleared", irq, 1'b0);

    // Reset during WR of word 1
    wc = wr_count;
    start_xfer(32'h40, 32'h500, 4);
    repeat (3) @(posedge clk);
    #1;
    dm_gnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_in_wr", dm_req, 1'b1);
    chk("t6_wr_addr", dm_a, 14'h501);
    rst = 1'b1;
    #1;
    chk("t6_web_now", dm_web, 4'hF);
    chk("t6_req_now", dm_req, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    dm_gnt = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_writes", wr_count - wc, 1);
    chk("t6_dm0", dm_mem[16'h500], 32'hC0);
    chk("t6_dm1", dm_mem[16'h501], 32'h0);
    read_reg(2'd3, v);
    chk("t6_status", v, 32'h0);
    chk("t6_irq", irq, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wm_dma.md
# wm_dma

Memory-mapped copy engine that moves a block of 32-bit words from the weight memory (WM) SRAM into the data memory (DM) SRAM. The CPU programs it through a four-register config port, sets a start bit, and then polls or waits on `irq`. It sits between the WM read port and the DM arbiter inside `top`. Its output is the DM-resident data that the program consumes and that the bench later compares against golden values.

## Interface

**Parameters**
- `ADDR_W`, 14: SRAM word-address width, shared by WM and DM.
- `DATA_W`, 32: word width.

**Ports**
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `cfg_we`  in  1: config write strobe.
- `cfg_addr`  in  2: register select.
  - 0 = SRC (WM word address)
  - 1 = DST (DM word address)
  - 2 = LEN (word count)
  - 3 = CTRL/STATUS
- `cfg_wdata`  in  32: write data.
- `cfg_rdata`  out  32: combinational readback of the register selected by `cfg_addr`.
- `wm_cs`, `wm_oe`  out  1 each: WM chip select and output enable.
- `wm_a`  out  ADDR_W: WM address.
- `wm_do`  in  DATA_W: WM read data, valid one cycle after the address is presented.
- `dm_req`  out  1: DM access request.
- `dm_gnt`  in  1: DM grant. The write takes effect on the edge where `dm_req && dm_gnt`.
- `dm_a`  out  ADDR_W: DM address.
- `dm_web`  out  4: DM byte write enables, active-low.
- `dm_di`  out  DATA_W: DM write data.
- `irq`  out  1: level output, equal to the done flag.

## Operation

**Registers**
- SRC, DST and LEN use bits `[ADDR_W-1:0]`; upper bits are written as ignored and read as 0.
- CTRL write:
  - bit0 = start.
  - bit1 = clear done (write-1-to-clear).
- STATUS read:
  - bit0 = busy.
  - bit1 = done.

**FSM states**

*IDLE*
- On start with LEN≠0:
  - load `src_cnt` = SRC, `dst_cnt` = DST, `rem` = LEN;
  - busy = 1, done = 0;
  - go to RD.
- On start with LEN=0: done = 1 at that edge, stay in IDLE, no SRAM activity.

*RD*
- Drive `wm_cs` = `wm_oe` = 1 and `wm_a` = `src_cnt`.
- Go to CAP.

*CAP*
- Register `wm_do` into `data_q`.
- Go to WR.

*WR*
- Drive `dm_req` = 1, `dm_a` = `dst_cnt`, `dm_web` = 4'b0000, `dm_di` = `data_q`.
- If `dm_gnt` is low: stay in WR with all outputs held stable.
- If `dm_gnt` is high: increment `src_cnt` and `dst_cnt`, decrement `rem`.
  - If `rem` was 1: go to IDLE with busy = 0, done = 1.
  - Otherwise: go to RD.

**Rules**
- Counters are `ADDR_W` bits wide and wrap modulo 2^ADDR_W (0x3FFF+1 → 0x0000).
- While busy, writes to SRC/DST/LEN and start are ignored. Clear-done is still honoured.
- A CTRL write carrying both start and clear-done in IDLE: the clear is applied first, then start. Result is done = 0, busy = 1 (or done = 1 if LEN=0).
- `cfg_rdata` reflects the programmed registers, not the running counters.

**Reset values**
- State IDLE.
- SRC = DST = LEN = 0; busy = done = 0.
- `wm_cs` = `wm_oe` = 0, `wm_a` = 0.
- `dm_req` = 0, `dm_a` = 0, `dm_web` = 4'hF, `dm_di` = 0.
- `irq` = 0.

**Reset mid-transfer**
- The transfer aborts immediately (asynchronous).
- No further WM reads or DM writes. A word that was in WR but not yet granted is not written.

## Timing
- WM read latency is 1 cycle: the address is presented in RD and the data is sampled in CAP.
- Each word takes 3 cycles with `dm_gnt` tied high, plus one cycle for every cycle spent in WR with `dm_gnt` low.
- With `dm_gnt` = 1: done/`irq` rise at the edge 3·LEN cycles after the edge that captured start.
- With LEN=0: done/`irq` rise at the start edge itself.
- `dm_web` is low only in the WR state. At all other times it is 4'hF.
- Outputs are decoded from registered state, with no combinational path from `dm_gnt` to the outputs. Exception: `cfg_rdata` is combinational from `cfg_addr`.

## Structure
- Package `wm_dma_pkg`:
  - state enum `{IDLE, RD, CAP, WR}`;
  - register offset constants `REG_SRC`, `REG_DST`, `REG_LEN`, `REG_CTRL`;
  - CTRL/STATUS bit indices.
- Single module, no sub-modules. The config register file and the FSM both live in `wm_dma`.

## Test plan
1. **Basic copy**
   - Stimulus: WM[0x10..0x13] = 0xA0..0xA3; SRC = 0x10, DST = 0x2000, LEN = 4, start; `dm_gnt` = 1.
   - Required: DM[0x2000..0x2003] = 0xA0..0xA3; `irq` rises 12 cycles after the start edge; STATUS = 0x2.
2. **Zero length**
   - Stimulus: LEN = 0, start.
   - Required: done = 1 at the start edge; `dm_req` and `wm_cs` never assert; busy never 1.
3. **Stalled grant**
   - Stimulus: LEN = 2; `dm_gnt` held low for 5 cycles during word 0.
   - Required: `dm_req`, `dm_a` and `dm_di` stay stable throughout the stall; exactly 2 DM writes; `irq` at 6+5 = 11 cycles after start.
4. **Address wrap**
   - Stimulus: SRC = 0x3FFE, DST = 0x3FFF, LEN = 3.
   - Required: WM addresses read are 0x3FFE, 0x3FFF, 0x0000; DM addresses written are 0x3FFF, 0x0000, 0x0001.
5. **Writes while busy**
   - Stimulus: during a LEN = 4 transfer, write SRC = 0x100 and start again.
   - Required: the transfer is unaffected; SRC readback is unchanged; exactly 4 writes occur.
   - Follow-up: writing CTRL = 0x2 after done makes `irq` = 0 on the next edge.
6. **Reset mid-transfer**
   - Stimulus: assert `rst` during the WR state of word 1 of a LEN = 4 transfer.
   - Required: `dm_web` = 4'hF and `dm_req` = 0 immediately; only word 0 is present in DM; STATUS = 0 after reset.
